// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the memory arbiter
// FSM states, port owner encoding and timeout counter width.
package cpu_types_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
   typedef enum logic {OWN_I, OWN_D} arb_owner_t;
   localparam int ARB_TIMEOUT_W = 8;
   localparam int WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - loadable timeout counter with terminal count
// tc flags the cycle on which count reaches limit-1; limit 0 never terminates.
module mem_arb_timer
   import cpu_types_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     en,
   input  logic                     load,
   input  logic [ARB_TIMEOUT_W-1:0] load_val,
   input  logic [ARB_TIMEOUT_W-1:0] limit,
   output logic                     tc
);
   logic [ARB_TIMEOUT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     count <= '0;
      else if (clear) count <= '0;
      else if (load)  count <= load_val;
      else if (en)    count <= count + 1'b1;
   end

   assign tc = (limit != '0) && (count == limit - 1'b1);
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-RAM arbiter for instruction and data ports
// MEM_ARBITER_STATS_EN enables the completed-access counters.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              ihit,
   output logic [ADDR_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [ADDR_W-1:0] dstore,
   output logic              dhit,
   output logic [ADDR_W-1:0] dload,
   input  logic              halt,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [ADDR_W-1:0] ramstore,
   input  logic [ADDR_W-1:0] ramload,
   input  logic              ram_ready,
   output logic              err,
   output logic [31:0]       stat_iacc,
   output logic [31:0]       stat_dacc
);
   arb_state_t        state, state_next;
   arb_owner_t        owner, last_owner;
   logic              write_q, err_q;
   logic [ADDR_W-1:0] addr_q, store_q, data_q, iload_q, dload_q;
   logic              d_req, i_req, grant_d, in_access, in_done, tmr_tc, dload_upd;

   assign d_req     = dREN | dWEN;
   assign i_req     = iREN & ~halt;
   assign grant_d   = d_req & (~i_req | (last_owner != OWN_D));
   assign in_access = (state == ACCESS);
   assign in_done   = (state == DONE);

   mem_arb_timer u_timer (
      .clk      (CLK),
      .rst_n    (nRST),
      .clear    (state == IDLE),
      .en       (in_access),
      .load     (1'b0),
      .load_val ('0),
      .limit    (ARB_TIMEOUT_W'(TIMEOUT)),
      .tc       (tmr_tc)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (d_req | i_req)     state_next = ACCESS;
         ACCESS:  if (ram_ready | tmr_tc) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         owner      <= OWN_I;
         last_owner <= OWN_I;
         write_q    <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         store_q    <= '0;
         data_q     <= '0;
         iload_q    <= '0;
         dload_q    <= '0;
      end else begin
         if (state == IDLE && (d_req | i_req)) begin
            owner   <= grant_d ? OWN_D : OWN_I;
            write_q <= grant_d & dWEN;
            addr_q  <= grant_d ? daddr : iaddr;
            store_q <= (grant_d & dWEN) ? dstore : '0;
            err_q   <= 1'b0;
         end
         // ready on the terminal cycle still counts as a good access
         if (in_access) begin
            if (ram_ready) begin
               data_q <= write_q ? '0 : ramload;
            end else if (tmr_tc) begin
               data_q <= '0;
               err_q  <= 1'b1;
            end
         end
         if (in_done) begin
            last_owner <= owner;
            if (ihit)      iload_q <= data_q;
            if (dload_upd) dload_q <= data_q;
         end
      end
   end

   assign ihit      = in_done & (owner == OWN_I) & iREN;
   assign dhit      = in_done & (owner == OWN_D) & d_req;
   assign dload_upd = dhit & (~write_q | err_q);
   assign iload     = ihit ? data_q : iload_q;
   assign dload     = dload_upd ? data_q : dload_q;
   assign err       = err_q & (ihit | dhit);
   assign ramREN    = in_access & ~write_q;
   assign ramWEN    = in_access & write_q;
   assign ramaddr   = addr_q;
   assign ramstore  = store_q;

`ifdef MEM_ARBITER_STATS_EN
   logic [31:0] iacc_q, dacc_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         iacc_q <= '0;
         dacc_q <= '0;
      end else if (in_done) begin
         if (owner == OWN_I) iacc_q <= iacc_q + 32'd1;
         else                dacc_q <= dacc_q + 32'd1;
      end
   end

   assign stat_iacc = iacc_q;
   assign stat_dacc = dacc_q;
`else
   assign stat_iacc = '0;
   assign stat_dacc = '0;
`endif
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported RAM between the instruction-fetch port and the data-access port of the datapath.
- Sits between the datapath/request unit and the RAM model.
- Serialises requests and returns per-port hit pulses plus load data.
- Applies alternating priority, halt gating and a RAM timeout.

Parameters:
- TIMEOUT, 255: maximum cycles to wait for ram_ready before aborting the access (8-bit counter; 0 disables the timeout).
- ADDR_W, 32: width of address and data words (word_t).

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous reset, active-low
- iREN  in  1  instruction read request, level
- iaddr  in  32  instruction address
- ihit  out  1  one-cycle pulse: iload valid
- iload  out  32  instruction word
- dREN  in  1  data read request, level
- dWEN  in  1  data write request, level
- daddr  in  32  data address
- dstore  in  32  data write value
- dhit  out  1  one-cycle pulse: data access complete
- dload  out  32  data read value
- halt  in  1  processor halted; blocks new fetches
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ram_ready  in  1  RAM access complete this cycle
- err  out  1  one-cycle pulse with a hit when the access timed out
- stat_iacc  out  32  completed instruction accesses
- stat_dacc  out  32  completed data accesses

Behaviour:
- Clock and reset: one clock, CLK; reset nRST is asynchronous and active-low.
- Reset values: all outputs are 0; state IDLE; last_owner = I; counters = 0.
- FSM states:
  - IDLE: sample requests.
  - ACCESS: RAM strobes driven from registered op/addr/data.
  - DONE: pulse hit for the owner.
- Request recognition:
  - A data request is dREN|dWEN.
  - dWEN wins if both dREN and dWEN are high; the access is a write.
  - An instruction request is iREN & !halt.
- Grant in IDLE:
  - Only D pending: grant D. Only I pending: grant I.
  - Both pending: grant D unless last_owner = D, in which case grant I.
  - On grant, register owner, op, address and store data, then go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - ramREN/ramWEN, ramaddr and ramstore come only from registers; they are stable for the whole access.
  - On ram_ready: capture ramload for reads, go to DONE.
  - The timeout counter increments each ACCESS cycle. When it reaches TIMEOUT with no ram_ready, go to DONE with the error flag set and load data = 0.
- DONE (one cycle):
  - Assert ihit or dhit according to owner, with iload/dload valid; err is high if the access timed out.
  - Update last_owner and increment the matching stat counter. Next state is IDLE.
- Latency: grant at cycle 0 (IDLE); RAM strobe at cycles 1..1+k; hit at cycle 2+k, where k = cycles until ram_ready. Minimum 3 cycles from request to hit.
- RAM strobes are 0 in IDLE and DONE.
- iload/dload hold their last value between hits.
- Request withdrawn mid-access: the RAM access still completes, but the hit is suppressed if the owner's request is low in DONE. The stat counter still increments.
- Halt:
  - Asserted during an I access: that access completes normally.
  - While halted, D requests are still served.
- Stat counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- Reset mid-operation: strobes drop combinationally, the FSM goes to IDLE, and no hit is issued.

Optional Feature:
- MEM_ARBITER_STATS_EN defined: stat_iacc and stat_dacc counters are implemented as described above.
- Not defined: no counter flops; stat_iacc and stat_dacc are tied to 0.

Decomposition:
- cpu_types_pkg gains:
  - arb_state_t enum {IDLE, ACCESS, DONE}
  - arb_owner_t enum {OWN_I, OWN_D}
  - ARB_TIMEOUT_W = 8
- Sub-module mem_arb_timer: a loadable 8-bit counter with clear/enable and a terminal-count output, used for the timeout.

Test Plan:
- iREN=1, iaddr=0x0000_0040, RAM ready after 2 cycles with 0x8C220004 -> ramREN high for cycles 1-3, ihit at cycle 4, iload=0x8C220004.
- iREN=1 and dWEN=1 together from reset, daddr=0x100, dstore=0xDEADBEEF -> D granted first, ramWEN with 0x100/0xDEADBEEF, dhit; then I granted, ihit.
- I and D both held continuously, ram_ready immediate -> grants alternate D,I,D,I; hits every 3 cycles.
- halt=1 with iREN=1 and dREN=1 at daddr=0x200 -> only dhit; ramREN is never driven with iaddr.
- ram_ready held low, TIMEOUT=4 -> hit with err=1 and load=0 after the timeout; FSM back in IDLE.
- nRST pulsed low during ACCESS -> ramREN/ramWEN drop at once, no hit; a clean access succeeds after release.
